oet_sorter_param: RTL and testbench

Parametrised odd-even transposition sorter: accepts N unsigned W-bit elements in one valid/ready beat and sorts them in place with one compare-swap phase per clk rising edge. It supports ascending or descending order per job and terminates early once the data is sorted. Output uses a valid/ready handshake and is the successor to the fixed 5x8-bit dual-edge sorter. The whole block runs on a single clock edge.

---
 rtl/oet_sorter_param.sv | 165 ++++++++++++++++
 tb/tb_oet_sorter_param.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oet_sorter_param.sv
// Parametrised odd-even transposition sorter.
// Loads N unsigned W-bit elements in one valid/ready beat, then runs one compare-swap phase per
// rising clk edge. Even phases compare pairs (0,1),(2,3)...; odd phases compare (1,2),(3,4)....
// The job ends early once two consecutive phases make no swap, or after N phases at most.
// The result is presented with a valid/ready handshake. It holds, together with phases_used,
// until the next job completes.
module oet_sorter_param #(
  parameter int unsigned N  = 5,
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           in_desc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic [CW-1:0]  phases_used
);

  typedef enum logic [1:0] {
    StIdle,
    StSort,
    StDone
  } state_e;

  localparam logic [CW-1:0] LastPhase = CW'(N - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    elem_q [N];
  logic [W-1:0]    elem_d [N];
  logic [W-1:0]    phase_elem [N];
  logic            desc_q, desc_d;
  logic [CW-1:0]   p_q, p_d;
  logic            prev_swap_q, prev_swap_d;
  logic [N*W-1:0]  out_q, out_d;
  logic [CW-1:0]   phases_q, phases_d;

  logic [N-2:0]    swap_vec;
  logic            swap_any;
  logic            odd_phase;
  logic            exit_phase;

  assign odd_phase = p_q[0];

  // One compare-swap phase over the current element registers.
  // Pairs of one parity never overlap, so every swap reads elem_q directly.
  always_comb begin
    swap_vec = '0;
    for (int i = 0; i < int'(N); i++) begin
      phase_elem[i] = elem_q[i];
    end
    for (int i = 0; i < int'(N) - 1; i++) begin
      if ((i % 2 == 1) == odd_phase) begin
        swap_vec[i] = desc_q ? (elem_q[i] < elem_q[i+1]) : (elem_q[i] > elem_q[i+1]);
      end
      if (swap_vec[i]) begin
        phase_elem[i]   = elem_q[i+1];
        phase_elem[i+1] = elem_q[i];
      end
    end
    swap_any = |swap_vec;
  end

  // Termination: the last possible phase, or a quiet phase that follows another quiet phase.
  always_comb begin
    exit_phase = (p_q == LastPhase) || ((p_q != '0) && !swap_any && !prev_swap_q);
  end

  // Next-state logic for the controller and the datapath registers.
  always_comb begin
    state_d     = state_q;
    desc_d      = desc_q;
    p_d         = p_q;
    prev_swap_d = prev_swap_q;
    out_d       = out_q;
    phases_d    = phases_q;
    for (int i = 0; i < int'(N); i++) begin
      elem_d[i] = elem_q[i];
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          for (int i = 0; i < int'(N); i++) begin
            elem_d[i] = in_data[i*W +: W];
          end
          desc_d      = in_desc;
          p_d         = '0;
          // Start with prev_swap set so that phase 0 can never end the job alone.
          prev_swap_d = 1'b1;
          state_d     = StSort;
        end
      end
      StSort: begin
        for (int i = 0; i < int'(N); i++) begin
          elem_d[i] = phase_elem[i];
        end
        if (exit_phase) begin
          for (int i = 0; i < int'(N); i++) begin
            out_d[i*W +: W] = phase_elem[i];
          end
          phases_d = p_q + CW'(1);
          state_d  = StDone;
        end else begin
          prev_swap_d = swap_any;
          p_d         = p_q + CW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; an asynchronous reset aborts any job in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      desc_q      <= 1'b0;
      p_q         <= '0;
      prev_swap_q <= 1'b0;
      out_q       <= '0;
      phases_q    <= '0;
      for (int i = 0; i < int'(N); i++) begin
        elem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      desc_q      <= desc_d;
      p_q         <= p_d;
      prev_swap_q <= prev_swap_d;
      out_q       <= out_d;
      phases_q    <= phases_d;
      for (int i = 0; i < int'(N); i++) begin
        elem_q[i] <= elem_d[i];
      end
    end
  end

  // Outputs are decoded from state or driven directly from registers.
  always_comb begin
    in_ready    = (state_q == StIdle);
    out_valid   = (state_q == StDone);
    out_data    = out_q;
    phases_used = phases_q;
  end

  // A stalled result must not move.
  a_out_stable : assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> ($stable(out_data) && $stable(phases_used)));

  // Any presented result took between 2 and N phases.
  a_phase_range : assert property (@(posedge clk) disable iff (reset)
    out_valid |-> ((phases_used >= CW'(2)) && (phases_used <= CW'(N))));

endmodule

// File: tb/tb_oet_sorter_param.sv
// Self-checking bench for oet_sorter_param.
// Three builds are exercised: N=5/W=8 (directed cases and random jobs), N=2/W=4, and
// N=8/W=16 (1000 random jobs). Expected results come from a queue sort. Expected phase
// counts come from a plain array replay of the odd-even transposition rules.
module tb_oet_sorter_param;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // Build A: N=5, W=8
  logic         a_in_valid, a_in_ready, a_in_desc, a_out_valid, a_out_ready;
  logic [39:0]  a_in_data, a_out_data;
  logic [2:0]   a_phases;
  // Build B: N=2, W=4
  logic         b_in_valid, b_in_ready, b_in_desc, b_out_valid, b_out_ready;
  logic [7:0]   b_in_data, b_out_data;
  logic [1:0]   b_phases;
  // Build C: N=8, W=16
  logic         c_in_valid, c_in_ready, c_in_desc, c_out_valid, c_out_ready;
  logic [127:0] c_in_data, c_out_data;
  logic [3:0]   c_phases;

  oet_sorter_param #(.N(5), .W(8)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_desc(a_in_desc), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .phases_used(a_phases)
  );
  oet_sorter_param #(.N(2), .W(4)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_desc(b_in_desc), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .phases_used(b_phases)
  );
  oet_sorter_param #(.N(8), .W(16)) u_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_desc(c_in_desc), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .phases_used(c_phases)
  );

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  int exp_ph;
  int vin[8];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int n_of(input int s);
    return (s == 0) ? 5 : (s == 1) ? 2 : 8;
  endfunction

  function automatic int w_of(input int s);
    return (s == 0) ? 8 : (s == 1) ? 4 : 16;
  endfunction

  function automatic logic [127:0] out_data_of(input int s);
    return (s == 0) ? 128'(a_out_data) : (s == 1) ? 128'(b_out_data) : c_out_data;
  endfunction

  function automatic logic [127:0] phases_of(input int s);
    return (s == 0) ? 128'(a_phases) : (s == 1) ? 128'(b_phases) : 128'(c_phases);
  endfunction

  function automatic logic out_valid_of(input int s);
    return (s == 0) ? a_out_valid : (s == 1) ? b_out_valid : c_out_valid;
  endfunction

  function automatic logic in_ready_of(input int s);
    return (s == 0) ? a_in_ready : (s == 1) ? b_in_ready : c_in_ready;
  endfunction

  task automatic drive(input int s, input logic [127:0] d, input bit desc, input bit v,
                       input bit r);
    case (s)
      0: begin a_in_data = d[39:0]; a_in_desc = desc; a_in_valid = v; a_out_ready = r; end
      1: begin b_in_data = d[7:0];  b_in_desc = desc; b_in_valid = v; b_out_ready = r; end
      default: begin c_in_data = d; c_in_desc = desc; c_in_valid = v; c_out_ready = r; end
    endcase
  endtask

  // Reference: final order from a library sort; phase count by replaying the phase rules.
  task automatic model(input int n, input int v[8], input bit desc);
    int e[8];
    bit prev, swp;
    int t;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
    if (desc) exp_q.rsort();
    else exp_q.sort();
    e = v;
    prev = 1'b1;
    exp_ph = n;
    for (int p = 0; p < n; p++) begin
      swp = 1'b0;
      for (int i = p % 2; i + 1 < n; i += 2) begin
        if (desc ? (e[i] < e[i+1]) : (e[i] > e[i+1])) begin
          t = e[i]; e[i] = e[i+1]; e[i+1] = t;
          swp = 1'b1;
        end
      end
      if ((p >= 1 && !swp && !prev) || p == n - 1) begin
        exp_ph = p + 1;
        break;
      end
      prev = swp;
    end
  endtask

  function automatic logic [127:0] pack(input int s, input int v[8]);
    logic [127:0] d = '0;
    for (int i = 0; i < n_of(s); i++) d |= (128'(v[i]) << (i * w_of(s)));
    return d;
  endfunction

  // Full job: accept, count latency, check result and phases, hand the result off.
  task automatic run_job(input int s, input int v[8], input bit desc, input int want_ph,
                         input string tag);
    int n, w, cyc, eph;
    logic [127:0] d, mask;
    n = n_of(s);
    w = w_of(s);
    mask = (128'(1) << w) - 1;
    d = pack(s, v);
    model(n, v, desc);
    eph = (want_ph >= 0) ? want_ph : exp_ph;
    @(negedge clk);
    check({tag, "/in_ready"}, in_ready_of(s), 1'b1);
    drive(s, d, desc, 1'b1, 1'b0);
    @(negedge clk);
    drive(s, d, desc, 1'b0, 1'b0);
    cyc = 0;
    while (!out_valid_of(s) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "/latency"}, 128'(cyc), 128'(eph));
    check({tag, "/phases"}, phases_of(s), 128'(eph));
    for (int i = 0; i < n; i++)
      check($sformatf("%s/e%0d", tag, i), (out_data_of(s) >> (i * w)) & mask, 128'(exp_q[i]));
    if (s == 2) check({tag, "/ph_le_8"}, 128'(phases_of(s) <= 8), 128'(1));
    drive(s, d, desc, 1'b0, 1'b1);
    @(negedge clk);
    check({tag, "/valid_drop"}, out_valid_of(s), 1'b0);
    check({tag, "/ready_back"}, in_ready_of(s), 1'b1);
    drive(s, d, desc, 1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [127:0] sorted5;
    reset = 1'b1;
    drive(0, '0, 1'b0, 1'b0, 1'b0);
    drive(1, '0, 1'b0, 1'b0, 1'b0);
    drive(2, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst%0d/out_valid", s), out_valid_of(s), 1'b0);
      check($sformatf("rst%0d/in_ready", s), in_ready_of(s), 1'b1);
      check($sformatf("rst%0d/out_data", s), out_data_of(s), '0);
      check($sformatf("rst%0d/phases", s), phases_of(s), '0);
    end
    reset = 1'b0;

    // Directed N=5 cases
    vin = '{5, 1, 4, 2, 3, 0, 0, 0};     run_job(0, vin, 1'b0, 5, "mix_asc");
    vin = '{1, 2, 3, 4, 5, 0, 0, 0};     run_job(0, vin, 1'b0, 2, "sorted_asc");
    vin = '{1, 2, 3, 4, 5, 0, 0, 0};     run_job(0, vin, 1'b1, 5, "sorted_desc");
    vin = '{7, 7, 0, 7, 0, 0, 0, 0};     run_job(0, vin, 1'b0, -1, "dups_asc");
    vin = '{255, 0, 255, 0, 128, 0, 0, 0}; run_job(0, vin, 1'b1, -1, "extreme_desc");

    // Backpressure: result held for 4 cycles while the input side is toggled
    vin = '{5, 1, 4, 2, 3, 0, 0, 0};
    sorted5 = 128'(40'h05_04_03_02_01);
    @(negedge clk);
    drive(0, pack(0, vin), 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(0, pack(0, vin), 1'b0, 1'b0, 1'b0);
    cyc = 0;
    while (!a_out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("bp/latency", 128'(cyc), 128'(5));
    for (int k = 0; k < 4; k++) begin
      drive(0, 128'({$urandom, $urandom}), k[0], !k[0], 1'b0);
      @(negedge clk);
      check($sformatf("bp%0d/out_valid", k), a_out_valid, 1'b1);
      check($sformatf("bp%0d/in_ready", k), a_in_ready, 1'b0);
      check($sformatf("bp%0d/out_data", k), 128'(a_out_data), sorted5);
      check($sformatf("bp%0d/phases", k), 128'(a_phases), 128'(5));
    end
    drive(0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("bp/release_valid", a_out_valid, 1'b0);
    check("bp/release_ready", a_in_ready, 1'b1);
    drive(0, '0, 1'b0, 1'b0, 1'b0);
    vin = '{2, 9, 4, 4, 1, 0, 0, 0};     run_job(0, vin, 1'b1, -1, "after_bp");

    // Reset while phase 2 of a job is being computed
    vin = '{5, 1, 4, 2, 3, 0, 0, 0};
    @(negedge clk);
    drive(0, pack(0, vin), 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(0, pack(0, vin), 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst/out_valid", a_out_valid, 1'b0);
    check("midrst/out_data", 128'(a_out_data), '0);
    check("midrst/in_ready", a_in_ready, 1'b1);
    check("midrst/phases", 128'(a_phases), '0);
    @(negedge clk);
    reset = 1'b0;
    vin = '{9, 8, 7, 6, 5, 0, 0, 0};     run_job(0, vin, 1'b0, -1, "post_rst");

    // Random N=5 jobs
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < 8; i++) vin[i] = (i < 5) ? int'($urandom_range(0, 255)) : 0;
      run_job(0, vin, 1'($urandom_range(0, 1)), -1, $sformatf("a_rand%0d", j));
    end

    // N=2 build
    vin = '{3, 1, 0, 0, 0, 0, 0, 0};     run_job(1, vin, 1'b0, 2, "n2_asc");
    for (int j = 0; j < 20; j++) begin
      for (int i = 0; i < 8; i++) vin[i] = (i < 2) ? int'($urandom_range(0, 15)) : 0;
      run_job(1, vin, 1'($urandom_range(0, 1)), -1, $sformatf("b_rand%0d", j));
    end

    // N=8 build, random jobs
    for (int j = 0; j < 1000; j++) begin
      for (int i = 0; i < 8; i++) vin[i] = int'($urandom_range(0, 65535));
      run_job(2, vin, 1'($urandom_range(0, 1)), -1, $sformatf("c_rand%0d", j));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
